// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default address width and Gray/binary conversion.
// Callers zero-extend narrower pointers into these and truncate the result back.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int FIFO_MAXW     = 32;

  function automatic logic [FIFO_MAXW-1:0] bin2gray(input logic [FIFO_MAXW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix-XOR from the MSB down; zero-extended upper bits leave the low bits exact.
  function automatic logic [FIFO_MAXW-1:0] gray2bin(input logic [FIFO_MAXW-1:0] g);
    logic [FIFO_MAXW-1:0] b;
    b[FIFO_MAXW-1] = g[FIFO_MAXW-1];
    for (int i = FIFO_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_cnt.sv
// Async-FIFO read-side pointer, empty/almost-empty flags, occupancy and sticky underflow.
// All outputs registered, one rclk of latency; reads while empty are refused and flagged.
module rptr_empty_cnt
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = FIFO_ADDRSIZE,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                runderflow
);

  typedef logic [ADDRSIZE:0] ptr_t;

  localparam ptr_t AE_LIMIT = ptr_t'(AE_THRESH);

  ptr_t rbin;
  ptr_t rbinnext;
  ptr_t rgraynext;
  ptr_t wbin;
  ptr_t rcount_next;
  logic rd_en;
  logic rempty_next;
  logic ralmost_next;
  logic runderflow_next;

  assign raddr = rbin[ADDRSIZE-1:0];

  // Flags are derived from the post-read pointer and the current sync'd write pointer,
  // so a read and a write-pointer update on the same cycle are both accounted for.
  always_comb begin
    rd_en           = rinc & ~rempty;
    rbinnext        = rbin + ptr_t'(rd_en);
    rgraynext       = ptr_t'(bin2gray(FIFO_MAXW'(rbinnext)));
    wbin            = ptr_t'(gray2bin(FIFO_MAXW'(rq2_wptr)));
    rcount_next     = wbin - rbinnext;
    rempty_next     = (rgraynext == rq2_wptr);
    ralmost_next    = (rcount_next <= AE_LIMIT);
    runderflow_next = runderflow | (rinc & rempty);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rcount        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= rempty_next;
      ralmost_empty <= ralmost_next;
      rcount        <= rcount_next;
      runderflow    <= runderflow_next;
    end
  end

endmodule

// File: tb/tb_rptr_empty_cnt.sv
// Directed bench for rptr_empty_cnt (ADDRSIZE=4, AE_THRESH=2); inputs change and
// outputs are sampled on the falling edge of rclk.
module tb_rptr_empty_cnt;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rinc = 1'b0;
  logic [4:0] rq2_wptr = 5'b0;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rcount;
  logic       runderflow;

  int n_checks = 0;
  int n_pass   = 0;

  rptr_empty_cnt #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rcount        (rcount),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic apply_reset();
    rinc     = 1'b0;
    rq2_wptr = 5'b0;
    @(negedge rclk);
    rrst_n = 1'b0;
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // Read n entries back-to-back with rinc held high.
  task automatic read_n(input int n);
    rinc = 1'b1;
    repeat (n) @(negedge rclk);
    rinc = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({rptr, raddr, rempty, ralmost_empty, rcount, runderflow} !== {5'd0, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0})
      $display("FAIL reset_state: got rptr=%b raddr=%0d re=%b rae=%b cnt=%0d uf=%b want 00000/0/1/1/0/0",
               rptr, raddr, rempty, ralmost_empty, rcount, runderflow);
    else n_pass++;

    // Put a read in flight, then assert reset between edges.
    rq2_wptr = 5'b00010;
    @(negedge rclk);
    rinc = 1'b1;
    @(negedge rclk);
    #2 rrst_n = 1'b0;
    #1;
    n_checks++;
    if ({rptr, raddr, rempty, ralmost_empty, rcount, runderflow} !== {5'd0, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0})
      $display("FAIL reset_async: got rptr=%b raddr=%0d re=%b rae=%b cnt=%0d uf=%b want 00000/0/1/1/0/0",
               rptr, raddr, rempty, ralmost_empty, rcount, runderflow);
    else n_pass++;
    rinc = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);
    n_checks++;
    if (rcount !== 5'd3 || rptr !== 5'd0 || rempty !== 1'b0)
      $display("FAIL reset_release: got cnt=%0d rptr=%b re=%b want 3/00000/0", rcount, rptr, rempty);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [4:0] exp_cnt [3] = '{5'd2, 5'd1, 5'd0};
    apply_reset();
    rq2_wptr = 5'b00010;
    rinc     = 1'b0;
    @(negedge rclk);
    n_checks++;
    if (rempty !== 1'b0 || rcount !== 5'd3 || ralmost_empty !== 1'b0)
      $display("FAIL first_fill: got re=%b cnt=%0d rae=%b want 0/3/0", rempty, rcount, ralmost_empty);
    else n_pass++;

    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (raddr !== 4'(i))
        $display("FAIL drain_raddr%0d: got %0d want %0d", i, raddr, i);
      else n_pass++;
      @(negedge rclk);
      n_checks++;
      if (rcount !== exp_cnt[i] || ralmost_empty !== 1'b1 || rempty !== (i == 2))
        $display("FAIL drain_flags%0d: got cnt=%0d rae=%b re=%b want %0d/1/%0d",
                 i, rcount, ralmost_empty, rempty, exp_cnt[i], (i == 2));
      else n_pass++;
    end
    n_checks++;
    if (rptr !== 5'b00010 || runderflow !== 1'b0)
      $display("FAIL drain_end: got rptr=%b uf=%b want 00010/0", rptr, runderflow);
    else n_pass++;
  endtask

  // Continues from the drained state: rinc is still high with the FIFO empty.
  task automatic test_underflow();
    @(negedge rclk);
    rinc = 1'b0;
    n_checks++;
    if (rptr !== 5'b00010 || raddr !== 4'd3 || runderflow !== 1'b1)
      $display("FAIL underflow_set: got rptr=%b raddr=%0d uf=%b want 00010/3/1", rptr, raddr, runderflow);
    else n_pass++;
    repeat (10) @(negedge rclk);
    n_checks++;
    if (runderflow !== 1'b1 || rptr !== 5'b00010)
      $display("FAIL underflow_sticky: got uf=%b rptr=%b want 1/00010", runderflow, rptr);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (runderflow !== 1'b0)
      $display("FAIL underflow_clear: got %b want 0", runderflow);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    apply_reset();
    rq2_wptr = 5'b11000;   // gray(16)
    @(negedge rclk);
    read_n(16);
    rq2_wptr = 5'b10001;   // gray(30)
    @(negedge rclk);
    read_n(14);
    n_checks++;
    if (rempty !== 1'b1 || raddr !== 4'd14 || rptr !== 5'b10001)
      $display("FAIL wrap_setup: got re=%b raddr=%0d rptr=%b want 1/14/10001", rempty, raddr, rptr);
    else n_pass++;
    rq2_wptr = 5'b00011;   // gray(2), next lap
    @(negedge rclk);
    n_checks++;
    if (rcount !== 5'd4 || rempty !== 1'b0)
      $display("FAIL wrap_count: got cnt=%0d re=%b want 4/0", rcount, rempty);
    else n_pass++;
    rinc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (raddr !== exp_addr[i])
        $display("FAIL wrap_raddr%0d: got %0d want %0d", i, raddr, exp_addr[i]);
      else n_pass++;
      @(negedge rclk);
    end
    rinc = 1'b0;
    n_checks++;
    if (rptr !== 5'b00011 || rempty !== 1'b1 || rcount !== 5'd0)
      $display("FAIL wrap_end: got rptr=%b re=%b cnt=%0d want 00011/1/0", rptr, rempty, rcount);
    else n_pass++;
  endtask

  task automatic test_full_and_concurrent();
    apply_reset();
    rq2_wptr = 5'b11000;   // gray(16)
    @(negedge rclk);
    n_checks++;
    if (rcount !== 5'd16 || rempty !== 1'b0 || ralmost_empty !== 1'b0)
      $display("FAIL full_occ: got cnt=%0d re=%b rae=%b want 16/0/0", rcount, rempty, ralmost_empty);
    else n_pass++;
    // Read and write-pointer advance on the same edge: occupancy stays at 16.
    rinc     = 1'b1;
    rq2_wptr = 5'b11001;   // gray(17)
    @(negedge rclk);
    rinc = 1'b0;
    n_checks++;
    if (rcount !== 5'd16 || rptr !== 5'b00001 || rempty !== 1'b0)
      $display("FAIL concurrent: got cnt=%0d rptr=%b re=%b want 16/00001/0", rcount, rptr, rempty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_full_and_concurrent();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
